// File: rtl/vec_mem_sequencer.sv
// Executes one vector load/store as LANES in-order byte transactions on a
// single-outstanding memory port, stalling the pipeline while it runs.
module vec_mem_sequencer #(
  parameter int LANES  = 16,
  parameter int LANE_W = 8,
  parameter int ADDR_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      is_store,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [LANES*LANE_W-1:0]   store_data,
  output logic                      stall,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [LANE_W-1:0]         mem_wdata,
  input  logic                      mem_ack,
  input  logic [LANE_W-1:0]         mem_rdata,
  output logic [LANES*LANE_W-1:0]   load_data,
  output logic                      load_valid,
  output logic                      done
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;

  state_e                    state_q, state_d;
  logic [LW-1:0]             lane_q, lane_d;
  logic                      st_q, st_d;
  logic [ADDR_W-1:0]         base_q, base_d;
  logic [LANES*LANE_W-1:0]   sdata_q, sdata_d;
  logic [LANES*LANE_W-1:0]   ldata_q, ldata_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lane_q  <= '0;
      st_q    <= 1'b0;
      base_q  <= '0;
      sdata_q <= '0;
      ldata_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      st_q    <= st_d;
      base_q  <= base_d;
      sdata_q <= sdata_d;
      ldata_q <= ldata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    st_d    = st_q;
    base_d  = base_q;
    sdata_d = sdata_q;
    ldata_d = ldata_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          st_d    = is_store;
          base_d  = base_addr;
          sdata_d = store_data;
          lane_d  = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (mem_ack) begin
          if (!st_q) ldata_d[lane_q*LANE_W +: LANE_W] = mem_rdata;
          if (lane_q == LAST_LANE) state_d = DONE;
          else                     lane_d  = lane_q + LW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // mem_* are gated by XFER so they sit at their reset values outside an op
  always_comb begin
    mem_req    = (state_q == XFER);
    mem_we     = (state_q == XFER) && st_q;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (state_q == XFER) begin
      mem_addr  = base_q + ADDR_W'(lane_q);
      mem_wdata = sdata_q[lane_q*LANE_W +: LANE_W];
    end
    done       = (state_q == DONE);
    load_valid = (state_q == DONE) && !st_q;
    stall      = ((state_q == IDLE) && start) || (state_q == XFER);
    load_data  = ldata_q;
  end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Scoreboard bench for vec_mem_sequencer: expected transactions and load
// vectors are queued at issue and retired as the memory model acks them.
module tb_vec_mem_sequencer;

  localparam int LANES  = 16;
  localparam int LANE_W = 8;
  localparam int ADDR_W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         is_store = 1'b0;
  logic [31:0]  base_addr = '0;
  logic [127:0] store_data = '0;
  logic         stall, mem_req, mem_we, load_valid, done;
  logic [31:0]  mem_addr;
  logic [7:0]   mem_wdata;
  logic         mem_ack = 1'b0;
  logic [7:0]   mem_rdata = '0;
  logic [127:0] load_data;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } txn_t;

  txn_t         exp_q[$];
  logic [127:0] ld_q[$];
  logic [127:0] last_load = '0;
  int           n_checks = 0;
  int           n_errors = 0;

  vec_mem_sequencer #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
    .base_addr(base_addr), .store_data(store_data), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .load_data(load_data), .load_valid(load_valid), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},   mem_req, 0);
    check_eq({tag, "_we"},    mem_we, 0);
    check_eq({tag, "_addr"},  mem_addr, 0);
    check_eq({tag, "_wdata"}, mem_wdata, 0);
    check_eq({tag, "_stall"}, stall, 0);
    check_eq({tag, "_done"},  done, 0);
    check_eq({tag, "_lv"},    load_valid, 0);
    check_eq({tag, "_ld"},    load_data, 0);
  endtask

  task automatic idle_cycles(input int n, input bit ack);
    for (int k = 0; k < n; k++) begin
      mem_ack   = ack;
      mem_rdata = 8'h5A;
      @(negedge clk);
      check_eq("idle_req", mem_req, 0);
      check_eq("idle_stall", stall, 0);
      check_eq("idle_done", done, 0);
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
  endtask

  // Called just after a rising edge; start is presented in that cycle (cycle 0).
  task automatic run_op(input bit st, input logic [31:0] base, input logic [127:0] sd,
                        input logic [7:0] rbase, input int wlane, input int wcyc,
                        input bit noise, input int abort_lane);
    int           lane, waited;
    bit           fin;
    logic [127:0] exp_ld;
    txn_t         t;
    exp_ld = '0;
    for (int i = 0; i < LANES; i++) begin
      t.addr  = base + 32'(i);
      t.we    = st;
      t.wdata = sd[i*8 +: 8];
      exp_q.push_back(t);
      exp_ld[i*8 +: 8] = rbase + 8'(i);
    end
    if (!st) ld_q.push_back(exp_ld);

    start = 1'b1; is_store = st; base_addr = base; store_data = sd;
    @(negedge clk);
    check_eq("c0_stall", stall, 1);
    check_eq("c0_req", mem_req, 0);
    @(posedge clk); #1;
    start = noise;
    if (noise) begin
      is_store = ~st; base_addr = 32'hDEAD_0000; store_data = ~sd;
    end

    lane = 0; waited = 0; fin = 0;
    for (int c = 1; c <= 200 && !fin; c++) begin
      @(negedge clk);
      if (mem_req && lane == abort_lane) begin
        mem_ack = 1'b0;
        rst_n   = 1'b0;
        #1;
        check_reset_outputs("abort");
        exp_q.delete();
        ld_q.delete();
        last_load = '0;
        @(posedge clk); #1;
        check_eq("abort_done", done, 0);
        check_eq("abort_req2", mem_req, 0);
        @(negedge clk);
        rst_n = 1'b1;
        fin = 1;
      end else if (mem_req) begin
        check_eq("req_pending", exp_q.size() != 0, 1);
        check_eq("xfer_stall", stall, 1);
        check_eq("xfer_done", done, 0);
        if (exp_q.size() != 0) begin
          check_eq("addr", mem_addr, exp_q[0].addr);
          check_eq("we", mem_we, exp_q[0].we);
          if (st) check_eq("wdata", mem_wdata, exp_q[0].wdata);
        end
        if (lane == wlane && waited < wcyc) begin
          mem_ack = 1'b0; mem_rdata = 8'h00; waited++;
        end else begin
          mem_ack = 1'b1; mem_rdata = rbase + 8'(lane);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          lane++;
        end
      end else begin
        mem_ack = noise;
        check_eq("done", done, 1);
        check_eq("done_cycle", c, LANES + 1 + wcyc);
        check_eq("done_lanes", lane, LANES);
        check_eq("done_stall", stall, 0);
        check_eq("load_valid", load_valid, !st);
        if (!st) begin
          check_eq("ld_pending", ld_q.size() != 0, 1);
          if (ld_q.size() != 0) begin
            last_load = ld_q.pop_front();
            check_eq("load_data", load_data, last_load);
          end
        end else begin
          check_eq("ld_kept", load_data, last_load);
        end
        fin = 1;
      end
      @(posedge clk); #1;
    end
    check_eq("op_finished", fin, 1);
    start = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    logic [127:0] sd;
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    idle_cycles(3, 1'b1);

    for (int i = 0; i < LANES; i++) sd[i*8 +: 8] = 8'(i);
    run_op(1'b1, 32'h0000_0100, sd, 8'h00, -1, 0, 1'b0, -1);

    run_op(1'b0, 32'h0000_0040, '0, 8'hA0, 5, 2, 1'b1, -1);
    run_op(1'b0, 32'hFFFF_FFF8, '0, 8'h5C, -1, 0, 1'b0, -1);
    idle_cycles(2, 1'b1);

    sd = {$urandom, $urandom, $urandom, $urandom};
    run_op(1'b1, 32'h1234_5670, sd, 8'h00, 3, 1, 1'b0, -1);

    run_op(1'b0, 32'h0000_0200, '0, 8'h10, -1, 0, 1'b0, 7);
    run_op(1'b0, 32'h0000_0300, '0, 8'hC3, 15, 3, 1'b0, -1);
    idle_cycles(2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
